// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM side of the memory arbiter.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BUSY   = 2'b01,
      ACCESS = 2'b10,
      ERROR  = 2'b11
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISERV = 2'b01,
      DSERV = 2'b10
   } arb_state_t;

   // Identifies which cache was served most recently, for round-robin.
   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } requester_t;

endpackage

// File: rtl/mem_watchdog.sv
// Service-time watchdog: counts stalled service cycles and flags the
// cycle in which a granted access has waited TIMEOUT-1 cycles.
module mem_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_q, count_d;

   assign expired = run && (count_q == LAST);

   // Next count: cleared outside service or on expiry, otherwise advance while stalled.
   always_comb begin
      count_d = count_q;
      if (clear || expired) begin
         count_d = '0;
      end else if (run) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Grants the single RAM port to the icache or the dcache, one access at a
// time, and releases the granted wait on ACCESS, ERROR or watchdog expiry.
//
//   state | meaning
//   ------+-------------------------------------------
//   IDLE  | no grant; both waits high, RAM port quiet
//   ISERV | icache owns the RAM port
//   DSERV | dcache owns the RAM port
//
// Address/data are passed through from the owner rather than latched, so
// completion can be signalled in the same cycle the RAM reports it.
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int    TIMEOUT = 64,
   parameter word_t ERRWORD = 32'hBAD1BAD1
) (
   input  logic      CLK,
   input  logic      RST,
   input  logic      iREN,
   input  word_t     iaddr,
   output logic      iwait,
   output word_t     iload,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      dwait,
   output word_t     dload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   output logic      memerr
);

   arb_state_t state_q, state_d;
   requester_t last_q, last_d;

   logic d_req;
   logic serve_i, serve_d, serving;
   logic req_live;
   logic hit_access, hit_error;
   logic wd_expired;
   logic done, fail;

   assign d_req      = dREN | dWEN;
   // A reset cycle never shows a grant, so nothing is released mid-reset.
   assign serve_i    = (state_q == ISERV) && !RST;
   assign serve_d    = (state_q == DSERV) && !RST;
   assign serving    = serve_i | serve_d;
   assign req_live   = (serve_i && iREN) || (serve_d && d_req);
   assign hit_access = (ramstate == ACCESS);
   assign hit_error  = (ramstate == ERROR);
   assign done       = req_live && hit_access;
   assign fail       = req_live && !hit_access && (hit_error || wd_expired);

   mem_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (CLK),
      .rst     (RST),
      .clear   (!serving),
      .run     (req_live && !hit_access && !hit_error),
      .expired (wd_expired)
   );

   // RAM port and cache response muxing for the current owner.
   always_comb begin
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      memerr   = 1'b0;
      if (serve_i) begin
         ramREN  = iREN;
         ramaddr = iaddr;
         if (done) begin
            iwait = 1'b0;
            iload = ramload;
         end else if (fail) begin
            iwait  = 1'b0;
            iload  = ERRWORD;
            memerr = 1'b1;
         end
      end else if (serve_d) begin
         // A simultaneous read and write is handled as a write.
         ramWEN   = dWEN;
         ramREN   = dREN & ~dWEN;
         ramaddr  = daddr;
         ramstore = dstore;
         if (done) begin
            dwait = 1'b0;
            dload = ramload;
         end else if (fail) begin
            dwait  = 1'b0;
            dload  = ERRWORD;
            memerr = 1'b1;
         end
      end
   end

   // Grant selection and return to IDLE after completion or withdrawal.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (d_req && (!iREN || last_q == REQ_I)) begin
               state_d = DSERV;
            end else if (iREN) begin
               state_d = ISERV;
            end
         end
         ISERV: begin
            if (!iREN) begin
               state_d = IDLE;
            end else if (done || fail) begin
               state_d = IDLE;
               last_d  = REQ_I;
            end
         end
         DSERV: begin
            if (!d_req) begin
               state_d = IDLE;
            end else if (done || fail) begin
               state_d = IDLE;
               last_d  = REQ_D;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and round-robin history registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         last_q  <= REQ_I;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

endmodule
